kyber_rej_sampler: RTL and testbench

//  Consumes SHAKE128 squeeze output (one 168-byte rate block per handshake) and performs

---
 rtl/kyber_rej_sampler.sv | 114 +++++++++++
 tb/tb_kyber_rej_sampler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_rej_sampler.sv
// rtl/kyber_rej_sampler.sv - Kyber uniform rejection sampler (Parse) over SHAKE128 squeeze blocks
module kyber_rej_sampler #(
  parameter int Q          = 3329,
  parameter int N          = 256,
  parameter int RATE_BYTES = 168
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [8*RATE_BYTES-1:0] blk_data,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  output logic [11:0]             coef,
  output logic [7:0]              coef_idx,
  output logic                    coef_valid,
  input  logic                    coef_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int BLK_W = 8 * RATE_BYTES;
  localparam int NCAND = 2 * RATE_BYTES / 3;
  localparam int CIW   = $clog2(NCAND);

  localparam logic [CIW-1:0] LAST_CAND = CIW'(NCAND - 1);
  localparam logic [8:0]     LAST_ACC  = 9'(N - 1);
  localparam logic [11:0]    Q_VAL     = 12'(Q);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_BLK = 2'd1;
  localparam logic [1:0] ST_PARSE    = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [1:0]       state;
  logic [BLK_W-1:0] blk_reg;
  logic [CIW-1:0]   cand_idx;
  logic [8:0]       acc_cnt;

  logic [23:0] grp;
  logic [11:0] cand_d;
  logic        accept;
  logic        in_parse;
  logic        advance;

  // The block register is shifted down by one 3-byte group after each odd
  // candidate, so the current group always sits in the low 24 bits.
  always_comb begin
    grp      = blk_reg[23:0];
    cand_d   = cand_idx[0] ? {grp[23:16], grp[15:12]} : {grp[11:8], grp[7:0]};
    accept   = (cand_d < Q_VAL);
    in_parse = (state == ST_PARSE);
    advance  = in_parse && (!accept || coef_ready);
  end

  // Outputs are decoded from registered state; coef fields read zero when not valid.
  always_comb begin
    coef_valid = in_parse && accept;
    coef       = coef_valid ? cand_d : 12'd0;
    coef_idx   = coef_valid ? acc_cnt[7:0] : 8'd0;
    blk_ready  = (state == ST_WAIT_BLK);
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
  end

  // Control FSM: request blocks, walk candidates, count accepted coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      blk_reg  <= '0;
      cand_idx <= '0;
      acc_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_cnt <= '0;
            state   <= ST_WAIT_BLK;
          end
        end
        ST_WAIT_BLK: begin
          if (blk_valid) begin
            blk_reg  <= blk_data;
            cand_idx <= '0;
            state    <= ST_PARSE;
          end
        end
        ST_PARSE: begin
          if (advance) begin
            if (accept) begin
              acc_cnt <= acc_cnt + 9'd1;
            end
            if (cand_idx[0]) begin
              blk_reg <= blk_reg >> 24;
            end
            cand_idx <= cand_idx + 1'b1;
            // Reaching N wins over running out of candidates.
            if (accept && (acc_cnt == LAST_ACC)) begin
              state <= ST_DONE;
            end else if (cand_idx == LAST_CAND) begin
              state <= ST_WAIT_BLK;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_rej_sampler.sv
// tb/tb_kyber_rej_sampler.sv - scoreboard bench for kyber_rej_sampler
module tb_kyber_rej_sampler;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1343:0] blk_data = '0;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic [11:0]   coef;
  logic [7:0]    coef_idx;
  logic          coef_valid;
  logic          coef_ready = 1'b0;
  logic          busy;
  logic          done;

  kyber_rej_sampler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .coef       (coef),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [19:0]   exp_q[$];
  logic [1343:0] blk_q[$];

  int blk_hs_cnt = 0;
  int coef_hs_cnt = 0;
  int coef_valid_cnt = 0;
  int done_cnt = 0;
  int last_hs_cyc = 0;
  int last_done_cyc = 0;
  int last_blk_hs_cyc = 0;
  bit pop_pending = 0;
  bit rand_ready = 0;

  logic        stalled = 1'b0;
  logic [11:0] st_coef = '0;
  logic [7:0]  st_idx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [11:0] v, input logic [7:0] i);
    exp_q.push_back({v, i});
  endtask

  task automatic push_zeros(input int first, input int last);
    for (int i = first; i <= last; i++) push_exp(12'd0, 8'(i));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (stalled) begin
      check("stall_valid", {31'd0, coef_valid}, 32'd1);
      check("stall_coef", {20'd0, coef}, {20'd0, st_coef});
      check("stall_idx", {24'd0, coef_idx}, {24'd0, st_idx});
    end
    stalled = coef_valid && !coef_ready && rst_n;
    st_coef = coef;
    st_idx  = coef_idx;
    if (coef_valid) coef_valid_cnt++;
    if (coef_valid && coef_ready) begin
      coef_hs_cnt++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got coef %0d idx %0d expected none", coef, coef_idx);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("sb_coef", {20'd0, coef}, {20'd0, e[19:8]});
        check("sb_idx", {24'd0, coef_idx}, {24'd0, e[7:0]});
      end
    end
    if (blk_valid && blk_ready) begin
      blk_hs_cnt++;
      last_blk_hs_cyc = cyc;
      pop_pending = 1;
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // Block source and optional random downstream back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending) begin
        pop_pending = 0;
        if (blk_q.size() != 0) void'(blk_q.pop_front());
      end
      blk_data = (blk_q.size() != 0) ? blk_q[0] : '0;
      if (rand_ready) coef_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int limit);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check(name, done_cnt - d0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_coef_valid"}, {31'd0, coef_valid}, 32'd0);
    check({tag, "_coef"}, {20'd0, coef}, 32'd0);
    check({tag, "_coef_idx"}, {24'd0, coef_idx}, 32'd0);
    check({tag, "_blk_ready"}, {31'd0, blk_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int h0, d0, v0, c0, n, rdy, base;
    logic [1343:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // blk_valid presented in IDLE is ignored
    blk_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_blk_ready", {31'd0, blk_ready}, 32'd0);
    end
    check("idle_no_capture", blk_hs_cnt, 0);

    // Test 1: all-zero blocks, coef_ready high
    coef_ready = 1'b1;
    push_zeros(0, 255);
    h0 = blk_hs_cnt;
    d0 = done_cnt;
    do_start();
    wait_done("t1_done", d0, 2000);
    check("t1_blocks", blk_hs_cnt - h0, 3);
    check("t1_sb_empty", exp_q.size(), 0);
    check("t1_done_latency", last_done_cyc - last_hs_cyc, 1);
    rdy = 0;
    repeat (150) begin
      @(negedge clk);
      if (blk_ready) rdy++;
    end
    check("t1_no_blk_ready_after", rdy, 0);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Tests 2/3: all-0xFF block, then a hand-built boundary block, then zeros
    b = '1;
    blk_q.push_back(b);
    b[0*8 +: 8] = 8'h01; b[1*8 +: 8] = 8'h0D; b[2*8 +: 8] = 8'h0D;
    b[3*8 +: 8] = 8'h00; b[4*8 +: 8] = 8'hD0; b[5*8 +: 8] = 8'hCF;
    b[6*8 +: 8] = 8'h00; b[7*8 +: 8] = 8'h0D; b[8*8 +: 8] = 8'hFF;
    blk_q.push_back(b);
    push_exp(12'd208, 8'd0);
    push_exp(12'd0, 8'd1);
    push_exp(12'd3325, 8'd2);
    push_exp(12'd3328, 8'd3);
    push_zeros(4, 255);
    h0 = blk_hs_cnt;
    d0 = done_cnt;
    v0 = coef_valid_cnt;
    do_start();
    n = 0;
    while (blk_hs_cnt == h0 && n < 200) begin @(posedge clk); #1; n++; end
    c0 = last_blk_hs_cyc;
    n = 0;
    while (blk_hs_cnt < h0 + 2 && n < 300) begin @(posedge clk); #1; n++; end
    check("t2_reassert_cycles", last_blk_hs_cyc - c0, 113);
    check("t2_no_coef_valid", coef_valid_cnt - v0, 0);
    wait_done("t3_done", d0, 2000);
    check("t3_blocks", blk_hs_cnt - h0, 5);
    check("t3_sb_empty", exp_q.size(), 0);

    // Tests 4/6: random back-pressure, stray start while busy
    rand_ready = 1;
    push_zeros(0, 255);
    h0 = blk_hs_cnt;
    d0 = done_cnt;
    do_start();
    repeat (60) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd1);
    wait_done("t4_done", d0, 5000);
    rand_ready = 0;
    @(posedge clk);
    #1 coef_ready = 1'b1;
    check("t4_blocks", blk_hs_cnt - h0, 3);
    check("t4_sb_empty", exp_q.size(), 0);
    repeat (10) @(posedge clk);
    check("t6_no_restart", done_cnt - d0, 1);
    check("t6_idle", {31'd0, busy}, 32'd0);

    // Test 5: asynchronous reset after 40 coefficients
    push_zeros(0, 39);
    base = coef_hs_cnt;
    do_start();
    n = 0;
    while (coef_hs_cnt - base < 40 && n < 500) begin @(posedge clk); #2; n++; end
    check("t5_count_before_reset", coef_hs_cnt - base, 40);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_reset");
    check("t5_sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_zeros(0, 255);
    h0 = blk_hs_cnt;
    d0 = done_cnt;
    do_start();
    wait_done("t5_restart_done", d0, 2000);
    check("t5_restart_blocks", blk_hs_cnt - h0, 3);
    check("t5_restart_sb_empty", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
